// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: E/M/W writer tracking, stall, rs/rt forward selects, HI/LO busy counter.
// Optional HAZARD_STATS_EN macro enables the saturating stall-cycle counter on stall_cnt.
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [4:0]  dst_d,
  input  logic [1:0]  tnew_d,
  input  logic        md_start_d,
  input  logic        md_div_d,
  input  logic        md_use_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
  } entry_t;

  entry_t     stgE;
  entry_t     stgM;
  entry_t     stgW;
  logic [3:0] cnt;
  logic       rsStall;
  logic       rtStall;
  logic       mdStall;

  function automatic logic hit(input entry_t s, input logic [4:0] r);
    return (r != 5'd0) && (s.addr == r);
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic opStall(
    input logic       u,
    input logic [4:0] r,
    input logic [1:0] tuse,
    input entry_t     e,
    input entry_t     m
  );
    return u && ((hit(e, r) && e.tnew > tuse) ||
                 (hit(m, r) && m.tnew > tuse));
  endfunction

  // Youngest matching stage owns the register, even if its data is not ready yet.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] r,
    input entry_t     e,
    input entry_t     m,
    input entry_t     w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(e, r))
      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(m, r))
      sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(w, r))
      sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    return sel;
  endfunction

  assign rsStall = opStall(use_rs, rs_d, tuse_rs, stgE, stgM);
  assign rtStall = opStall(use_rt, rt_d, tuse_rt, stgE, stgM);
  assign md_busy = (cnt != 4'd0);
  assign mdStall = md_use_d && md_busy;
  assign stall   = rsStall | rtStall | mdStall;

  assign fwd_rs_sel = fwdSel(rs_d, stgE, stgM, stgW);
  assign fwd_rt_sel = fwdSel(rt_d, stgE, stgM, stgW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stgE <= '0;
      stgM <= '0;
      stgW <= '0;
      cnt  <= '0;
    end else begin
      stgW <= '{addr: stgM.addr, tnew: satDec(stgM.tnew)};
      stgM <= '{addr: stgE.addr, tnew: satDec(stgE.tnew)};
      stgE <= stall ? '0 : '{addr: dst_d, tnew: tnew_d};
      if (!stall && md_start_d)
        cnt <= md_div_d ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random stimulus
// checked each cycle against a ready-time based reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs_d, rt_d, dst_d;
  logic        use_rs, use_rt;
  logic [1:0]  tuse_rs, tuse_rt, tnew_d;
  logic        md_start_d, md_div_d, md_use_d;
  logic        stall, md_busy;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  int total = 0;
  int passed = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d),
    .use_rs(use_rs), .use_rt(use_rt),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .dst_d(dst_d), .tnew_d(tnew_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d),
    .md_use_d(md_use_d),
    .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: each issued writer remembers the absolute cycle its result is ready.
  typedef struct {
    logic [4:0] dst;
    int         ready;
  } ent_t;

  ent_t pipe[3];
  int   cyc = 0;
  int   mdFree = 0;
  int   statCnt = 0;

  function automatic logic mOpStall(logic u, logic [4:0] r, logic [1:0] tuse);
    if (!u || r == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].dst == r && (pipe[k].ready - cyc) > int'(tuse))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mBusy();
    return cyc < mdFree;
  endfunction

  function automatic logic mStall();
    return mOpStall(use_rs, rs_d, tuse_rs) ||
           mOpStall(use_rt, rt_d, tuse_rt) ||
           (md_use_d && mBusy());
  endfunction

  function automatic logic [1:0] mSel(logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (pipe[k].dst == r)
        return (pipe[k].ready <= cyc) ? 2'(k + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [31:0] mStatCnt();
`ifdef HAZARD_STATS_EN
    return 32'(statCnt);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    logic s;
    for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 0};
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 0};
        cyc = 0;
        mdFree = 0;
        statCnt = 0;
      end else begin
        s = mStall();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = s ? '{5'd0, 0} : '{dst_d, cyc + 1 + int'(tnew_d)};
        if (!s && md_start_d)
          mdFree = cyc + 1 + (md_div_d ? 10 : 5);
        if (s) statCnt++;
        cyc++;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("stall", 32'(stall), 32'(mStall()));
      check("fwd_rs", 32'(fwd_rs_sel), 32'(mSel(rs_d)));
      check("fwd_rt", 32'(fwd_rt_sel), 32'(mSel(rt_d)));
      check("md_busy", 32'(md_busy), 32'(mBusy()));
      check("stall_cnt", stall_cnt, mStatCnt());
    end
  end

  task automatic idle();
    rs_d = 0; rt_d = 0; use_rs = 0; use_rt = 0;
    tuse_rs = 0; tuse_rt = 0; dst_d = 0; tnew_d = 0;
    md_start_d = 0; md_div_d = 0; md_use_d = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(int n);
    idle();
    repeat (n) step();
  endtask

  task automatic mdRun(logic isDiv, int expN, string name);
    int nSt;
    int nBusy;
    nSt = 0;
    nBusy = 0;
    idle();
    md_start_d = 1; md_div_d = isDiv; md_use_d = 1;
    step();
    idle();
    md_use_d = 1; dst_d = 8; tnew_d = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      nSt++;
      if (md_busy) nBusy++;
      step();
    end
    check({name, "_stalls"}, 32'(nSt), 32'(expN));
    check({name, "_busy"}, 32'(nBusy), 32'(expN));
    step();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(md_busy), 0);
    check("rst_sel", 32'({fwd_rs_sel, fwd_rt_sel}), 0);
    check("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    reset = 1;
    step();

    // lw $1 then addu reading $1
    idle(); dst_d = 1; tnew_d = 2;
    step();
    idle(); rs_d = 1; use_rs = 1; tuse_rs = 1; dst_d = 5; tnew_d = 1;
    @(negedge clk);
    check("lw_use_stall", 32'(stall), 1);
    step();
    @(negedge clk);
    check("lw_use_free", 32'(stall), 0);
    check("lw_use_sel_m", 32'(fwd_rs_sel), 0);
    step();
    @(negedge clk);
    check("lw_use_sel_w", 32'(fwd_rs_sel), 3);

    // addu $2 then beq on $2
    flush(4);
    dst_d = 2; tnew_d = 1;
    step();
    idle(); rs_d = 2; use_rs = 1; tuse_rs = 0;
    @(negedge clk);
    check("beq_stall", 32'(stall), 1);
    step();
    @(negedge clk);
    check("beq_free", 32'(stall), 0);
    check("beq_sel", 32'(fwd_rs_sel), 2);

    // lui $3 then sw with $3 as data
    flush(4);
    dst_d = 3; tnew_d = 0;
    step();
    idle(); rt_d = 3; use_rt = 1; tuse_rt = 2; use_rs = 1; tuse_rs = 1;
    @(negedge clk);
    check("sw_stall", 32'(stall), 0);
    check("sw_sel", 32'(fwd_rt_sel), 1);

    // $4 written from both E and M
    flush(4);
    dst_d = 4; tnew_d = 0;
    step();
    step();
    idle(); rs_d = 4; use_rs = 1; tuse_rs = 1; use_rt = 1;
    @(negedge clk);
    check("dual_sel", 32'(fwd_rs_sel), 1);
    check("zero_sel", 32'(fwd_rt_sel), 0);
    check("dual_stall", 32'(stall), 0);

    flush(4);
    mdRun(1'b0, 5, "mult");
    mdRun(1'b1, 10, "div");

    // async reset with count 7 and a load in E
    flush(12);
    md_start_d = 1; md_div_d = 1; md_use_d = 1;
    step();
    idle();
    step();
    step();
    dst_d = 6; tnew_d = 2;
    step();
    idle(); rs_d = 6; use_rs = 1; tuse_rs = 1; md_use_d = 1;
    @(negedge clk);
    check("pre_rst_stall", 32'(stall), 1);
    check("pre_rst_busy", 32'(md_busy), 1);
    reset = 0;
    #1;
    check("arst_stall", 32'(stall), 0);
    check("arst_busy", 32'(md_busy), 0);
    check("arst_cnt", stall_cnt, 0);
    idle();
    step();
    reset = 1;

    // three stall cycles behind a mult
    idle(); md_start_d = 1; md_use_d = 1;
    step();
    idle(); md_use_d = 1;
    repeat (3) step();
    idle();
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    check("stats3", stall_cnt, 3);
`else
    check("stats3", stall_cnt, 0);
`endif

    flush(12);
    for (int i = 0; i < 2000; i++) begin
      rs_d = 5'($urandom_range(0, 7));
      rt_d = 5'($urandom_range(0, 7));
      use_rs = 1'($urandom_range(0, 1));
      use_rt = 1'($urandom_range(0, 1));
      tuse_rs = 2'($urandom_range(0, 3));
      tuse_rt = 2'($urandom_range(0, 3));
      dst_d = 5'($urandom_range(0, 7));
      tnew_d = 2'($urandom_range(0, 3));
      md_start_d = ($urandom_range(0, 15) == 0);
      md_div_d = 1'($urandom_range(0, 1));
      md_use_d = md_start_d || ($urandom_range(0, 5) == 0);
      step();
    end

    idle();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
